// File: rtl/ifetch.sv
// Instruction fetch unit: drives imem, buffers {pc, instr} pairs in a small FIFO for decode,
// and restarts on redirects. Optional macro IFETCH_MISALIGN_CHECK_EN halts fetch on misaligned redirects.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } halt_t;

    logic [31:0]      fpc;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    halt_t            state;
    halt_t            state_next;
    logic [31:0]      redirect_target;
    logic             full;
    logic             pop;
    logic             push;

    assign imem_a    = fpc;
    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop frees a slot at the same edge, so a full FIFO still accepts one word per cycle.
    assign push      = !redirect && (state == RUN) && (!full || pop);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next      = state;
        redirect_target = {redirect_pc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (redirect) begin
            redirect_target = redirect_pc;
            state_next      = (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
        end
`endif
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misalign = (state == HALT);
`else
    logic unused_lsbs;
    assign unused_lsbs = ^redirect_pc[1:0];
    assign misalign    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Flush wins over any pop decode performs in the same cycle.
            fpc    <= redirect_target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fpc    <= fpc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fpc;
            instr_mem[wr_ptr] <= imem_rd;
        end
    end

    always_comb begin
        out_pc      = '0;
        out_instr   = '0;
        out_pcplus4 = '0;
        if (out_valid) begin
            out_pc      = pc_mem[rd_ptr];
            out_instr   = instr_mem[rd_ptr];
            out_pcplus4 = pc_mem[rd_ptr] + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a combinational imem model, a queue of expected head PCs,
// and immediate assertions at every comparison point.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_a     (imem_a),
        .imem_rd    (imem_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pcplus4(out_pcplus4),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .misalign   (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-addressed instruction memory; unlisted words get an address-derived pattern.
    function automatic logic [31:0] imem_model(input logic [31:0] addr);
        case (addr[31:2])
            30'd0:   return 32'h0050_0113;
            30'd1:   return 32'h00c0_0193;
            30'd2:   return 32'h01e0_0113;
            30'd3:   return 32'h0220_2423;
            default: return {addr[15:0] ^ 16'hBEEF, addr[31:16]};
        endcase
    endfunction

    assign imem_rd = imem_model(imem_a);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag);
        logic [31:0] pc;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            pc = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_pc"}, out_pc, pc);
            check({tag, "_instr"}, out_instr, imem_model(pc));
            check({tag, "_pcplus4"}, out_pcplus4, pc + 32'd4);
        end
    endtask

    task automatic do_reset(input logic ready);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = ready;
        exp_q.delete();
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pcplus4", out_pcplus4, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_imem_a", imem_a, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #20000;
        check("watchdog", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "FAIL watchdog expired");
    end

    initial begin
        // Straight-line fetch.
        do_reset(1'b1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        step(); expect_head("line0");
        step(); expect_head("line1");
        step(); expect_head("line2");

        // Backpressure: fill, hold, then drain without gaps or duplicates.
        do_reset(1'b0);
        step();
        check("bp_imem_a_1", imem_a, 32'h4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_imem_a_hold", imem_a, 32'h8);
        end
        exp_q.push_back(32'h0);
        expect_head("bp_head");
        out_ready = 1'b1;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        step(); expect_head("drain4");
        step(); expect_head("drain8");
        step(); expect_head("drainC");

        // Redirect with simultaneous pop while full.
        do_reset(1'b0);
        step();
        step();
        check("rd_full_imem_a", imem_a, 32'h8);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hC;
        step();
        redirect = 1'b0;
        check("rd_flush_valid", {31'd0, out_valid}, 32'd0);
        check("rd_imem_a", imem_a, 32'hC);
        exp_q.push_back(32'hC);
        step();
        check("rd_instr_const", out_instr, 32'h0220_2423);
        expect_head("rd_head");

        // Wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_flush_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        step();
        check("wrap_pcplus4_zero", out_pcplus4, 32'h0);
        expect_head("wrap_top");
        step(); expect_head("wrap_zero");

        // Misaligned redirect.
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        step();
        redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_valid", {31'd0, out_valid}, 32'd0);
        check("mis_imem_a", imem_a, 32'h6);
        step();
        step();
        check("mis_hold_valid", {31'd0, out_valid}, 32'd0);
        check("mis_hold_flag", {31'd0, misalign}, 32'd1);
        check("mis_hold_imem_a", imem_a, 32'h6);
        redirect    = 1'b1;
        redirect_pc = 32'h4;
        step();
        redirect = 1'b0;
        check("mis_clear_flag", {31'd0, misalign}, 32'd0);
        check("mis_clear_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'h4);
        step(); expect_head("mis_resume");
`else
        check("mis_off_flag", {31'd0, misalign}, 32'd0);
        check("mis_off_imem_a", imem_a, 32'h4);
        check("mis_off_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'h4);
        step(); expect_head("mis_off_head");
        check("mis_off_flag2", {31'd0, misalign}, 32'd0);
`endif

        // Asynchronous reset between clock edges.
        step();
        check("async_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_imem_a", imem_a, 32'h0);
        check("async_pc", out_pc, 32'h0);
        check("async_misalign", {31'd0, misalign}, 32'd0);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        step(); expect_head("restart0");
        step(); expect_head("restart4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the initiator side of the instruction memory interface. It drives a word address into the combinational instruction memory (`imem`), captures the returned word, and buffers {pc, instr} pairs in a small FIFO. Decode pulls entries through a valid/ready handshake. Execute redirects fetch on taken branches and jumps. The block sits between `imem` and the decode stage of the RISC-V core.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address loaded by reset.
- `DEPTH`, default 2: FIFO entries. Power of two, at least 2.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `imem_a`, out, 32: fetch address to `imem`. Equals the fetch PC register `fpc`.
- `imem_rd`, in, 32: instruction word from `imem`, valid in the same cycle as `imem_a`.
- `out_valid`, out, 1: FIFO head holds a valid entry.
- `out_ready`, in, 1: decode accepts the head this cycle.
- `out_instr`, out, 32: instruction at the FIFO head.
- `out_pc`, out, 32: PC of the FIFO head.
- `out_pcplus4`, out, 32: `out_pc` + 4, modulo 2^32.
- `redirect`, in, 1: flush the FIFO and restart fetch.
- `redirect_pc`, in, 32: new fetch address, sampled when `redirect`=1.
- `misalign`, out, 1: sticky misaligned-redirect flag. Behaviour set by `IFETCH_MISALIGN_CHECK_EN`.

## Operation
- Internal state: `fpc`, FIFO storage, read/write pointers, occupancy `count` (0..DEPTH), and a `halt` flag.
- Pop: occurs when `out_valid & out_ready`.
- Push: occurs when `!redirect & !halt & (count < DEPTH | pop)`. The pushed entry is {`fpc`, `imem_rd`}, and `fpc` advances to `fpc` + 4 at the same edge.
- Simultaneous push and pop: `count` is unchanged. A full FIFO still sustains one instruction per cycle.
- Redirect has priority over everything else:
  - at the edge, `count`←0 and the pointers reset;
  - `fpc`←`redirect_pc`;
  - no push occurs;
  - a pop in the same cycle is consumed by decode but its effect on `count` is overridden by the flush.
- When `count`=0: `out_valid`=0 and `out_instr`/`out_pc`/`out_pcplus4` are forced to 0.
- Arithmetic: all PC additions wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- No state machine beyond `halt`, which has two states: RUN and HALT (HALT is reachable only with the macro).

## Timing
- Reset values: `fpc`=`RESET_PC`, `count`=0, `halt`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_pcplus4`=0, `misalign`=0, `imem_a`=`RESET_PC`.
- After reset release:
  - first edge: push of `RESET_PC`;
  - next cycle: `out_valid`=1 with `out_pc`=`RESET_PC`.
- Redirect latency: `redirect` in cycle N → `imem_a`=target in N+1 → `out_valid`=1 with `out_pc`=target in N+2.
- Steady state with `out_ready`=1: one new instruction per cycle. `out_pc` increments by 4 each cycle.
- Backpressure: with `out_ready`=0, the FIFO fills in DEPTH cycles. Then `fpc` and `imem_a` hold, and the head is held stable.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, whatever handshake is in flight.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0]`≠0 loads `fpc` and sets `halt`=1 and `misalign`=1 (sticky);
  - while `halt`=1, no pushes occur;
  - a later redirect with an aligned target clears both flags;
  - reset also clears both flags.
- `IFETCH_MISALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is ignored and `fpc` is loaded with {`redirect_pc[31:2]`, 2'b00};
  - `halt` is never set and `misalign` is constant 0.

## Test plan
- Straight-line fetch: `imem` model has word0=32'h00500113, word1=32'h00c00193, word2=32'h01e00113; `out_ready`=1 → consecutive cycles show (pc 0, 00500113), (4, 00c00193), (8, 01e00113), with `out_pcplus4` = 4, 8, 12.
- Backpressure: `out_ready`=0 for 5 cycles after reset → `count` saturates at 2, `imem_a` holds 32'h8, and the head stays (0, 00500113). Raising `out_ready` drains pc 0, 4, 8 with no gap and no duplicates.
- Redirect with simultaneous pop while full: `redirect_pc`=32'hC → the FIFO is empty the next cycle, and two cycles later `out_pc`=32'hC with `out_instr`=32'h02202423.
- Wrap: redirect to 32'hFFFF_FFFC → that entry shows `out_pcplus4`=0, and the next entry has `out_pc`=0.
- Misalign, macro on: redirect to 32'h6 → `misalign`=1 and `out_valid` stays 0. A later redirect to 32'h4 clears `misalign`, and `out_pc`=4 appears two cycles later. Macro off: the same stimulus fetches from 32'h4 and `misalign` stays 0.
- Asynchronous reset asserted mid-stream between clock edges → `out_valid` and `count` are 0 immediately and `imem_a`=`RESET_PC`. Fetch restarts at pc 0.
